// File: rtl/mux_pkg.sv
// Shared constants for the registered N-way channel multiplexer.
package mux_pkg;
  localparam int WIDTH_DEF    = 4;
  localparam int CHANNELS_DEF = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/mux_n_reg_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping modulo CHANNELS.
// Purely combinational, no state and no backpressure.
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [SELW-1:0]     gnt_idx,
  output logic                gnt_any
);

  int cand;

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand = (int'(ptr) + k) % CHANNELS;
      if (req[SELW'(cand)]) begin
        gnt_idx = SELW'(cand);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Selects one of CHANNELS valid/ready inputs (fixed or round-robin) into a one-word output register.
// Latency 1 cycle; in_ready drops to 0 while a held word is stalled by out_ready = 0.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int NSEL = 1 << SELW;

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;
  logic [SELW-1:0] grant;
  logic            grant_any;
  logic            load_en;
  logic            in_xfer;
  logic [NSEL-1:0] valid_ext;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Zero-extended valids make a select beyond the last channel read as "not valid".
  assign valid_ext = NSEL'(in_valid);

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    if (mode == MODE_RR) begin
      grant     = rr_idx;
      grant_any = rr_any;
    end else begin
      grant     = sel;
      grant_any = valid_ext[sel];
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_xfer  = load_en && grant_any && !rst;
  assign in_ready = in_xfer ? (CHANNELS'(1) << grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(CHANNELS - 1);
    end else if (in_xfer) begin
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_chan  <= grant;
      out_valid <= 1'b1;
      if (mode == MODE_RR) begin
        ptr <= grant;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed and random checks of mux_n_reg against a transaction-level reference model.
module tb_mux_n_reg;
  localparam int W  = 4;
  localparam int CH = 4;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*W-1:0]   in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_chan;
  logic              out_valid;
  logic              out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model: the output register contents and the round-robin pointer.
  bit m_vld;
  int m_data;
  int m_chan;
  int m_ptr;

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(W), .CHANNELS(CH), .SELW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int chan_word(input int c);
    logic [CH*W-1:0] d;
    d = in_data;
    return int'(d[c*W +: W]);
  endfunction

  // Returns the granted channel, or -1 when nobody is granted this cycle.
  function automatic int model_grant();
    int g;
    g = -1;
    if (rst || (m_vld && !out_ready)) return -1;
    if (mode == 1'b0) begin
      if (int'(sel) < CH && in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 1; k <= CH; k++) begin
        if (g < 0 && in_valid[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
      end
    end
    return g;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    int g;
    logic [CH-1:0] exp_rdy;
    @(negedge clk);
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0; m_data = 0; m_chan = 0; m_ptr = CH - 1;
    end else if (g >= 0) begin
      m_vld = 1'b1; m_data = chan_word(g); m_chan = g;
      if (mode) m_ptr = g;
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_vld));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_chan", 32'(out_chan), 32'(m_chan));
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    m_vld = 1'b0; m_data = 0; m_chan = 0; m_ptr = CH - 1;

    // Reset, then idle with no valid inputs.
    cycle(); cycle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    cycle(); cycle();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Fixed select.
    out_ready = 1'b1; in_valid = 4'b1111; in_data = 16'h3_5_1_A;
    sel = 2'd0; cycle();
    check("fix0_data", 32'(out_data), 32'hA);
    check("fix0_chan", 32'(out_chan), 32'd0);
    sel = 2'd1; cycle();
    check("fix1_data", 32'(out_data), 32'h1);
    check("fix1_chan", 32'(out_chan), 32'd1);
    in_valid = 4'b1101; cycle();
    check("fix_nogrant_valid", 32'(out_valid), 32'd0);

    // Round-robin fairness, one word per cycle.
    mode = 1'b1; in_valid = 4'b1111; in_data = 16'hD_C_B_9;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_seq_chan", 32'(out_chan), 32'(i % CH));
      check("rr_seq_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: held for 3 cycles, then drain and refill on one edge.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_chan_held", 32'(out_chan), 32'd3);
      check("bp_data_held", 32'(out_data), 32'hD);
    end
    out_ready = 1'b1; cycle();
    check("bp_refill_chan", 32'(out_chan), 32'd0);

    // Wrap and skip from ptr = 2.
    in_valid = 4'b0100; cycle();
    check("wrap_setup_chan", 32'(out_chan), 32'd2);
    in_valid = 4'b0011;
    cycle(); check("wrap_g0", 32'(out_chan), 32'd0);
    cycle(); check("wrap_g1", 32'(out_chan), 32'd1);
    cycle(); check("wrap_g2", 32'(out_chan), 32'd0);

    // Mid-operation reset discards a stalled word and restarts priority at channel 0.
    in_valid = 4'b1111; out_ready = 1'b0; cycle();
    rst = 1'b1; cycle();
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1; cycle();
    check("midrst_chan", 32'(out_chan), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = CH'($urandom);
      in_data   = (CH*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
